// File: rtl/project_types.sv
// Shared CPU memory-bus types plus the SRAM controller state and sizing constants.
package project_types;

  localparam int unsigned RAM_ADDR_W          = 32;
  localparam int unsigned RAM_DATA_W          = 32;
  localparam int unsigned SRAM_ADDR_W_DEFAULT = 20;
  localparam int unsigned SRAM_WAIT_W         = $clog2(16);

  typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
  typedef logic [RAM_DATA_W-1:0] ram_data_t;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } sram_state_t;

endpackage

// File: rtl/i_membus.sv
// CPU data-memory bus between the MEM stage (master) and a memory controller (slave).
interface i_membus;

  logic                      we;
  project_types::chip_status_t ce;
  project_types::ram_addr_t  addr;
  project_types::ram_data_t  write;
  project_types::ram_data_t  read;

  modport master (output we, ce, addr, write, input read);
  modport slave  (input we, ce, addr, write, output read);

endinterface

// File: rtl/sram_membus_ctrl.sv
// Membus slave driving an asynchronous single-port SRAM with WAIT_CYCLES extra
// access cycles; stalls the pipeline from request until the access is done.
module sram_membus_ctrl
  import project_types::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  i_membus.slave                 bus,
  output logic                   stall_req,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_dq_o,
  input  logic [31:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  sram_state_t            state_q;
  sram_state_t            state_d;
  logic [SRAM_WAIT_W-1:0] cnt_q;
  logic                   we_q;
  ram_data_t              read_q;
  logic                   accept_c;
  logic                   last_c;
  logic                   unused_addr;

  assign accept_c = (state_q == IDLE) && (bus.ce == CHIP_ENABLE);
  assign last_c   = (state_q == ACCESS) && (cnt_q == '0);

  // Gated by rst_n so the hold drops with reset even while ce is still asserted.
  assign stall_req = rst_n && (accept_c || (state_q == ACCESS));
  assign bus.read  = read_q;

  // Byte offset and address bits above the SRAM window are not used.
  assign unused_addr = ^{bus.addr[RAM_ADDR_W-1:SRAM_ADDR_W+2], bus.addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ACCESS;
      ACCESS:  if (last_c)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are set on entry to ACCESS and released on its last edge, so they
  // come straight from flops and cover exactly the ACCESS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      read_q     <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else if (accept_c) begin
      cnt_q      <= SRAM_WAIT_W'(WAIT_CYCLES);
      we_q       <= bus.we;
      sram_addr  <= bus.addr[SRAM_ADDR_W+1:2];
      sram_dq_o  <= bus.write;
      sram_dq_oe <= bus.we;
      sram_ce_n  <= 1'b0;
      sram_oe_n  <= bus.we;
      sram_we_n  <= ~bus.we;
    end else if (state_q == ACCESS) begin
      if (!last_c) begin
        cnt_q <= cnt_q - SRAM_WAIT_W'(1);
      end else begin
        sram_dq_oe <= 1'b0;
        sram_ce_n  <= 1'b1;
        sram_oe_n  <= 1'b1;
        sram_we_n  <= 1'b1;
        if (!we_q) read_q <= sram_dq_i;
      end
    end
  end

endmodule
